// File: rtl/mips_datapath_pipeline_id_ex_pkg.sv
// rtl/mips_datapath_pipeline_id_ex_pkg.sv - shared types, bubble constant and field helpers for the ID/EX slot
package mips_datapath_pipeline_id_ex_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic       reads_rt;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic  valid;
    ctrl_t control;
    word_t instruction;
    word_t pc_addr;
    word_t port1;
    word_t port2;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic reg_addr_t rs_of(input word_t instr);
    return instr[25:21];
  endfunction

  function automatic reg_addr_t rt_of(input word_t instr);
    return instr[20:16];
  endfunction

  // Writeback forwarding; $0 is hard-wired and never takes forwarded data.
  function automatic word_t wb_bypass(input logic en, input reg_addr_t wa, input word_t wd,
                                      input reg_addr_t a, input word_t d);
    return (en && (wa == a) && (a != 5'd0)) ? wd : d;
  endfunction

endpackage

// File: rtl/mips_datapath_pipeline_id_ex_hazard.sv
// rtl/mips_datapath_pipeline_id_ex_hazard.sv - combinational load-use hazard detect
module mips_datapath_pipeline_id_ex_hazard
  import mips_datapath_pipeline_id_ex_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1
) (
  input  logic      ex_valid_i,
  input  logic      ex_mem_read_i,
  input  reg_addr_t ex_rt_i,
  input  reg_addr_t id_rs_i,
  input  reg_addr_t id_rt_i,
  input  logic      id_reads_rt_i,
  output logic      hazard_o
);

  logic rt_match;

  assign rt_match = (ex_rt_i == id_rs_i) || (id_reads_rt_i && (ex_rt_i == id_rt_i));
  assign hazard_o = (LOAD_USE_STALL != 0) && ex_valid_i && ex_mem_read_i &&
                    (ex_rt_i != 5'd0) && rt_match;

endmodule

// File: rtl/mips_datapath_pipeline_id_ex.sv
// rtl/mips_datapath_pipeline_id_ex.sv - single-slot ID/EX pipeline register with bypass and load-use bubble
module mips_datapath_pipeline_id_ex
  import mips_datapath_pipeline_id_ex_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      id_valid_i,
  output logic      id_ready_o,
  input  ctrl_t     control_i,
  input  word_t     instruction_i,
  input  word_t     pc_addr_i,
  input  word_t     port1_i,
  input  word_t     port2_i,
  input  logic      flush_i,
  input  logic      wb_wr_enable_i,
  input  reg_addr_t wb_wr_addr_i,
  input  word_t     wb_wr_data_i,
  input  logic      ex_ready_i,
  output logic      ex_valid_o,
  output ctrl_t     ex_control_o,
  output word_t     ex_instruction_o,
  output word_t     ex_pc_addr_o,
  output word_t     ex_port1_o,
  output word_t     ex_port2_o,
  output reg_addr_t ex_rs_o,
  output reg_addr_t ex_rt_o
);

  id_ex_t    slot_q, slot_d;
  logic      hazard;
  reg_addr_t in_rs, in_rt, held_rs, held_rt;

  assign in_rs   = rs_of(instruction_i);
  assign in_rt   = rt_of(instruction_i);
  assign held_rs = rs_of(slot_q.instruction);
  assign held_rt = rt_of(slot_q.instruction);

  mips_datapath_pipeline_id_ex_hazard #(
    .LOAD_USE_STALL(LOAD_USE_STALL)
  ) u_hazard (
    .ex_valid_i    (slot_q.valid),
    .ex_mem_read_i (slot_q.control.mem_read),
    .ex_rt_i       (held_rt),
    .id_rs_i       (in_rs),
    .id_rt_i       (in_rt),
    .id_reads_rt_i (control_i.reads_rt),
    .hazard_o      (hazard)
  );

  assign id_ready_o = (!slot_q.valid || ex_ready_i) && !hazard && !flush_i;

  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d = ID_EX_BUBBLE;
    end else if (id_valid_i && id_ready_o) begin
      slot_d.valid       = 1'b1;
      slot_d.control     = control_i;
      slot_d.instruction = instruction_i;
      slot_d.pc_addr     = pc_addr_i;
      slot_d.port1       = wb_bypass(wb_wr_enable_i, wb_wr_addr_i, wb_wr_data_i, in_rs, port1_i);
      slot_d.port2       = wb_bypass(wb_wr_enable_i, wb_wr_addr_i, wb_wr_data_i, in_rt, port2_i);
    end else if (slot_q.valid && !ex_ready_i) begin
      // Holding: keep operands fresh against writebacks landing while stalled.
      slot_d.port1 = wb_bypass(wb_wr_enable_i, wb_wr_addr_i, wb_wr_data_i, held_rs, slot_q.port1);
      slot_d.port2 = wb_bypass(wb_wr_enable_i, wb_wr_addr_i, wb_wr_data_i, held_rt, slot_q.port2);
    end else begin
      // Drained with nothing taken in (incl. load-use stall): empty slot / bubble.
      slot_d = ID_EX_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= ID_EX_BUBBLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign ex_valid_o       = slot_q.valid;
  assign ex_control_o     = slot_q.control;
  assign ex_instruction_o = slot_q.instruction;
  assign ex_pc_addr_o     = slot_q.pc_addr;
  assign ex_port1_o       = slot_q.port1;
  assign ex_port2_o       = slot_q.port2;
  assign ex_rs_o          = held_rs;
  assign ex_rt_o          = held_rt;

endmodule

// File: tb/tb_mips_datapath_pipeline_id_ex.sv
// tb/tb_mips_datapath_pipeline_id_ex.sv - directed vector bench for the ID/EX slot
module tb_mips_datapath_pipeline_id_ex;
  import mips_datapath_pipeline_id_ex_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      id_valid_i, id_ready_o, flush_i, wb_wr_enable_i, ex_ready_i, ex_valid_o;
  ctrl_t     control_i, ex_control_o;
  word_t     instruction_i, pc_addr_i, port1_i, port2_i, wb_wr_data_i;
  word_t     ex_instruction_o, ex_pc_addr_o, ex_port1_o, ex_port2_o;
  reg_addr_t wb_wr_addr_i, ex_rs_o, ex_rt_o;

  always #5 clk = ~clk;

  mips_datapath_pipeline_id_ex #(.LOAD_USE_STALL(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid_i       (id_valid_i),
    .id_ready_o       (id_ready_o),
    .control_i        (control_i),
    .instruction_i    (instruction_i),
    .pc_addr_i        (pc_addr_i),
    .port1_i          (port1_i),
    .port2_i          (port2_i),
    .flush_i          (flush_i),
    .wb_wr_enable_i   (wb_wr_enable_i),
    .wb_wr_addr_i     (wb_wr_addr_i),
    .wb_wr_data_i     (wb_wr_data_i),
    .ex_ready_i       (ex_ready_i),
    .ex_valid_o       (ex_valid_o),
    .ex_control_o     (ex_control_o),
    .ex_instruction_o (ex_instruction_o),
    .ex_pc_addr_o     (ex_pc_addr_o),
    .ex_port1_o       (ex_port1_o),
    .ex_port2_o       (ex_port2_o),
    .ex_rs_o          (ex_rs_o),
    .ex_rt_o          (ex_rt_o)
  );

  typedef struct {
    logic      iv;
    word_t     ins;
    word_t     a;
    word_t     b;
    ctrl_t     c;
    logic      fl;
    logic      we;
    reg_addr_t wa;
    word_t     wd;
    logic      er;
    logic      x_ready;
    logic      x_valid;
    ctrl_t     x_ctrl;
    word_t     x_ins;
    reg_addr_t x_rs;
    reg_addr_t x_rt;
    word_t     x_a;
    word_t     x_b;
  } vec_t;

  int passed = 0;
  int total  = 0;
  vec_t vecs[$];

  localparam word_t ADD_3_1_2 = 32'h0022_1820;
  localparam word_t LW_4_0_1  = 32'h8C24_0000;
  localparam word_t ADD_5_4_4 = 32'h0084_2820;
  localparam word_t ADD_7_6_0 = 32'h00C0_3820;
  localparam word_t ADD_7_0_6 = 32'h0006_3820;
  localparam word_t LW_4_4_2  = 32'h8C44_0004;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t v(input logic iv, input word_t ins, input word_t a, input word_t b,
                             input ctrl_t c, input logic fl, input logic we, input reg_addr_t wa,
                             input word_t wd, input logic er, input logic xr, input logic xv,
                             input ctrl_t xc, input word_t xi, input reg_addr_t xrs,
                             input reg_addr_t xrt, input word_t xa, input word_t xb);
    vec_t r;
    r.iv = iv; r.ins = ins; r.a = a; r.b = b; r.c = c; r.fl = fl;
    r.we = we; r.wa = wa; r.wd = wd; r.er = er;
    r.x_ready = xr; r.x_valid = xv; r.x_ctrl = xc; r.x_ins = xi;
    r.x_rs = xrs; r.x_rt = xrt; r.x_a = xa; r.x_b = xb;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    id_valid_i     = t.iv;
    instruction_i  = t.ins;
    pc_addr_i      = t.ins ^ 32'h0000_1000;
    port1_i        = t.a;
    port2_i        = t.b;
    control_i      = t.c;
    flush_i        = t.fl;
    wb_wr_enable_i = t.we;
    wb_wr_addr_i   = t.wa;
    wb_wr_data_i   = t.wd;
    ex_ready_i     = t.er;
  endtask

  initial begin
    ctrl_t c_add, c_lw, z;
    vec_t idle;
    z = '0;
    c_add = '0; c_add.reg_write = 1'b1; c_add.reg_dst = 1'b1; c_add.reads_rt = 1'b1; c_add.alu_op = 4'd2;
    c_lw  = '0; c_lw.reg_write = 1'b1; c_lw.mem_read = 1'b1; c_lw.mem_to_reg = 1'b1; c_lw.alu_src = 1'b1;

    //           iv ins        a       b      c      fl we wa  wd            er  rdy val ctrl   ins        rs  rt  a             b
    vecs.push_back(v(1, ADD_3_1_2, 5,      7,     c_add, 0, 0, 0, 0,            1,  1,  1, c_add, ADD_3_1_2, 1,  2,  5,            7));
    vecs.push_back(v(1, LW_4_0_1,  100,    0,     c_lw,  0, 0, 0, 0,            1,  1,  1, c_lw,  LW_4_0_1,  1,  4,  100,          0));
    vecs.push_back(v(1, ADD_5_4_4, 11,     22,    c_add, 0, 0, 0, 0,            1,  0,  0, z,     0,         0,  0,  0,            0));
    vecs.push_back(v(1, ADD_5_4_4, 11,     22,    c_add, 0, 0, 0, 0,            1,  1,  1, c_add, ADD_5_4_4, 4,  4,  11,           22));
    vecs.push_back(v(1, ADD_7_6_0, 0,      3,     c_add, 0, 1, 6, 32'hDEADBEEF, 1,  1,  1, c_add, ADD_7_6_0, 6,  0,  32'hDEADBEEF, 3));
    vecs.push_back(v(1, ADD_7_0_6, 32'h55, 9,     c_add, 0, 1, 0, 32'hDEADBEEF, 1,  1,  1, c_add, ADD_7_0_6, 0,  6,  32'h55,       9));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1, ADD_3_1_2, 1,    2,     c_add, 0, 0, 0, 0,            0,  0,  1, c_add, ADD_7_0_6, 0,  6,  32'h55,       9));
    vecs.push_back(v(1, ADD_3_1_2, 1,      2,     c_add, 0, 1, 6, 32'h1234,     0,  0,  1, c_add, ADD_7_0_6, 0,  6,  32'h55,       32'h1234));
    vecs.push_back(v(1, ADD_3_1_2, 1,      2,     c_add, 1, 0, 0, 0,            0,  0,  0, z,     0,         0,  0,  0,            0));
    vecs.push_back(v(1, ADD_3_1_2, 1,      2,     c_add, 1, 0, 0, 0,            1,  0,  0, z,     0,         0,  0,  0,            0));
    vecs.push_back(v(1, ADD_3_1_2, 5,      7,     c_add, 0, 0, 0, 0,            1,  1,  1, c_add, ADD_3_1_2, 1,  2,  5,            7));
    vecs.push_back(v(1, LW_4_0_1,  100,    0,     c_lw,  0, 0, 0, 0,            1,  1,  1, c_lw,  LW_4_0_1,  1,  4,  100,          0));
    vecs.push_back(v(1, LW_4_4_2,  200,    0,     c_lw,  0, 0, 0, 0,            1,  1,  1, c_lw,  LW_4_4_2,  2,  4,  200,          0));
    vecs.push_back(v(0, 0,         0,      0,     z,     0, 0, 0, 0,            1,  1,  0, z,     0,         0,  0,  0,            0));

    idle = v(0, 0, 0, 0, z, 0, 0, 0, 0, 0, 1, 0, z, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(negedge clk);
    chk("reset_ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("reset_ex_control", {19'd0, ex_control_o}, 32'd0);
    chk("reset_ex_port1", ex_port1_o, 32'd0);
    chk("reset_id_ready", {31'd0, id_ready_o}, 32'd1);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      chk($sformatf("v%0d_id_ready", k), {31'd0, id_ready_o}, {31'd0, vecs[k].x_ready});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ex_valid", k), {31'd0, ex_valid_o}, {31'd0, vecs[k].x_valid});
      chk($sformatf("v%0d_ex_control", k), {19'd0, ex_control_o}, {19'd0, vecs[k].x_ctrl});
      if (vecs[k].x_valid) begin
        chk($sformatf("v%0d_ex_instr", k), ex_instruction_o, vecs[k].x_ins);
        chk($sformatf("v%0d_ex_pc", k), ex_pc_addr_o, vecs[k].x_ins ^ 32'h0000_1000);
        chk($sformatf("v%0d_ex_rs", k), {27'd0, ex_rs_o}, {27'd0, vecs[k].x_rs});
        chk($sformatf("v%0d_ex_rt", k), {27'd0, ex_rt_o}, {27'd0, vecs[k].x_rt});
        chk($sformatf("v%0d_ex_port1", k), ex_port1_o, vecs[k].x_a);
        chk($sformatf("v%0d_ex_port2", k), ex_port2_o, vecs[k].x_b);
      end
    end

    // Asynchronous reset while holding a valid bundle.
    @(negedge clk);
    drive(v(1, ADD_3_1_2, 5, 7, c_add, 0, 0, 0, 0, 1, 1, 1, c_add, ADD_3_1_2, 1, 2, 5, 7));
    @(posedge clk);
    #1;
    chk("hold_pre_reset_valid", {31'd0, ex_valid_o}, 32'd1);
    @(negedge clk);
    drive(idle);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("async_reset_port1", ex_port1_o, 32'd0);
    chk("async_reset_instr", ex_instruction_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_id_ready", {31'd0, id_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_reset_valid", {31'd0, ex_valid_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_datapath_pipeline_id_ex.md
MIPS_DATAPATH_PIPELINE_ID_EX -- requirements
Module: Mips_Datapath_Pipeline_idEx

Interface
REQ-001 Parameter LOAD_USE_STALL, default 1, meaning: 1 enables internal load-use bubble insertion, 0 disables it (external hazard unit).
REQ-002 ctrl  input  Data_Control_Control_T  one clock (rising edge) plus reset; reset is asynchronous and active-low.
REQ-003 idValid  input  1  decode stage holds a valid instruction.
REQ-004 idReady  output  1  this stage accepts the decode bundle this cycle.
REQ-005 control  input  Mips_Control_Control_T  decoded control bundle.
REQ-006 instruction, pcAddr, port1, port2  input  Word each  decode instruction, PC+4, register read data rs/rt.
REQ-007 flush  input  1  taken branch/jump; kill captured and incoming instruction.
REQ-008 wbWrEnable, wbWrAddr, wbWrData  input  1/RegAddr/Word  writeback port, same cycle as register-file write.
REQ-009 exReady  input  1  execute stage consumes the held bundle this cycle.
REQ-010 exValid  output  1  held bundle is valid.
REQ-011 exControl, exInstruction, exPcAddr, exPort1, exPort2  output  Control/Word x4  held bundle.
REQ-012 exRs, exRt  output  RegAddr each  held rs/rt fields for downstream forwarding.

Function
REQ-013 Stage SHALL be one register slot; latency idValid&idReady to exValid is exactly 1 cycle.
REQ-014 Transfer in SHALL occur when idValid & idReady; transfer out when exValid & exReady.
REQ-015 idReady SHALL equal (!exValid | exReady) & !hazard & !flush.
REQ-016 hazard SHALL be 1 iff LOAD_USE_STALL=1, exValid, exControl MemRead set, exRt != 0, and exRt equals incoming rs, or equals incoming rt when incoming control reads rt.
REQ-017 On hazard with exReady=1 the slot SHALL load a bubble (exValid=0, exControl all-zero); decode holds its instruction; re-evaluated next cycle.
REQ-018 Slot states: EMPTY (exValid=0), FULL (exValid=1); EMPTY->FULL on transfer in; FULL->EMPTY on transfer out without transfer in; FULL->FULL on simultaneous out+in or on !exReady (hold, all outputs stable).
REQ-019 flush SHALL force exValid=0 and exControl=0 at the next edge, priority over transfer-in, hold and hazard.
REQ-020 Bypass: on capture, exPort1 SHALL take wbWrData if wbWrEnable & wbWrAddr==rs & wbWrAddr!=0, else port1; same rule for exPort2 with rt.
REQ-021 While FULL and holding, captured exPort1/exPort2 SHALL also be updated by a matching writeback (same rule) so held data never goes stale.
REQ-022 Register $0 SHALL never be bypassed or flagged as hazard.
REQ-023 When exValid=0, exControl SHALL be all-zero (no write, no memory access); data outputs don't-care.

Reset
REQ-024 ctrl reset low SHALL asynchronously clear exValid and all exControl, exInstruction, exPcAddr, exPort1, exPort2, exRs, exRt to 0.
REQ-025 Reset mid-hold SHALL drop the held instruction; first cycle after release idReady=1 (if no flush).

Structure
REQ-026 Shared package SHALL hold Mips_Pipeline_IdEx_T bundle macro with field accessors (Valid, Control, Instruction, PcAddr, Port1, Port2) and the all-zero bubble constant.
REQ-027 Load-use check SHALL be a combinational sub-module Mips_Datapath_Pipeline_hazard (inputs: held control/rt, exValid, incoming instruction/control; output hazard).
REQ-028 Block SHALL contain no other state than the single slot.

Verification
REQ-029 Reset low mid-hold with exValid=1 -> exValid=0, exPort1=0 immediately, before any clock edge.
REQ-030 add $3,$1,$2 with port1=5, port2=7, exReady=1 -> next cycle exValid=1, exPort1=5, exPort2=7, exRs=1, exRt=2.
REQ-031 Held lw $4,0($1) then incoming add $5,$4,$4 -> idReady=0 one cycle, bubble (exValid=0), then add captured.
REQ-032 Capture of rs=6 while wbWrEnable=1, wbWrAddr=6, wbWrData=0xDEAD_BEEF, port1=0 -> exPort1=0xDEAD_BEEF; repeat with wbWrAddr=0 -> exPort1=port1.
REQ-033 exReady=0 for 3 cycles with valid bundle -> outputs stable, idReady=0; flush asserted same cycle as idValid=1 -> exValid=0 next edge, input not captured.
